// File: rtl/ppm_pkg.sv
// ----------------------------------------------------------------------------
// ppm_pkg
// Shared definitions for the PPM receiver / servo driver family:
//   - servo_state_t : servo driver frame state (IDLE, LATCH, RUN)
//   - NUM_CHANNELS  : channel count shared with the receiver
//   - DEF_*         : default servo timing in microseconds
//   - clamp_us()    : saturate a 32-bit microsecond value into [lo, hi]
// No ports (package).
// ----------------------------------------------------------------------------
package ppm_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int DEF_MIN_US   = 1000;
  localparam int DEF_MAX_US   = 2000;
  localparam int DEF_FRAME_US = 20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    RUN   = 2'd2
  } servo_state_t;

  // Full 32-bit unsigned saturation; result always fits 16 bits since hi < 65536.
  function automatic logic [15:0] clamp_us(input logic [31:0] v,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    logic [31:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return 16'(r);
  endfunction

endpackage

// File: rtl/us_prescaler.sv
// ----------------------------------------------------------------------------
// us_prescaler
// Divides the system clock down to a one-cycle tick every microsecond.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clear    in   holds the divider at zero (no ticks) while high
//   us_tick  out  high on the last clock of each microsecond
// ----------------------------------------------------------------------------
module us_prescaler #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic us_tick
);

  localparam int            PW   = $clog2(CLK_PER_US);
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] r_count;

  // Free-running divider 0..CLK_PER_US-1, restarted by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PW'(1);
    end
  end

  assign us_tick = (r_count == LAST) && !clear;

endmodule

// File: rtl/ppm_servo_driver.sv
// ----------------------------------------------------------------------------
// ppm_servo_driver
// Regenerates eight hobby-servo PWM outputs from the PPM receiver's decoded
// channel widths. Widths are sampled once per frame into shadow registers so a
// receiver update can never produce a runt or stretched pulse.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   channels     in   8 x 32-bit pulse widths in microseconds
//   enable       in   run servo frames while high
//   servo_pwm    out  bit i = PWM output for channel i
//   frame_start  out  one-cycle pulse while in LATCH
//   clamp_flags  out  bit i = channel i was clamped at the last latch
//   absent_mask  out  bit i = channel i was 0 at the last latch
//   busy         out  high whenever not IDLE
// ----------------------------------------------------------------------------
module ppm_servo_driver
  import ppm_pkg::*;
#(
  parameter int CLK_PER_US = 50,
  parameter int FRAME_US   = DEF_FRAME_US,
  parameter int MIN_US     = DEF_MIN_US,
  parameter int MAX_US     = DEF_MAX_US
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             channels [NUM_CHANNELS],
  input  logic                    enable,
  output logic [NUM_CHANNELS-1:0] servo_pwm,
  output logic                    frame_start,
  output logic [NUM_CHANNELS-1:0] clamp_flags,
  output logic [NUM_CHANNELS-1:0] absent_mask,
  output logic                    busy
);

  localparam logic [31:0] MIN32      = 32'(MIN_US);
  localparam logic [31:0] MAX32      = 32'(MAX_US);
  localparam logic [31:0] FRAME_LAST = 32'(FRAME_US - 1);

  servo_state_t            r_state;
  logic [31:0]             r_us_count;
  logic [15:0]             r_shadow [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_pwm;
  logic                    r_frame_start;
  logic [NUM_CHANNELS-1:0] r_clamp;
  logic [NUM_CHANNELS-1:0] r_absent;
  logic                    r_busy;

  logic                    w_us_tick;
  logic                    w_clear;
  logic [31:0]             w_count_next;
  logic                    w_frame_end;
  logic [15:0]             w_shadow_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_clamp_next;
  logic [NUM_CHANNELS-1:0] w_absent_next;
  logic [NUM_CHANNELS-1:0] w_pwm_next;

  // The divider only runs inside a frame, so every frame starts phase-aligned.
  assign w_clear = (r_state != RUN);

  us_prescaler #(
    .CLK_PER_US(CLK_PER_US)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_clear),
    .us_tick(w_us_tick)
  );

  // The PWM register is loaded from the value us_count will hold next cycle,
  // so the output lines up with us_count and width is exactly shadow*CLK_PER_US.
  assign w_count_next = w_us_tick ? (r_us_count + 32'd1) : r_us_count;
  assign w_frame_end  = w_us_tick && (r_us_count == FRAME_LAST);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_absent_next[g] = (channels[g] == 32'd0);
    assign w_clamp_next[g]  = !w_absent_next[g] &&
                              ((channels[g] < MIN32) || (channels[g] > MAX32));
    assign w_shadow_next[g] = w_absent_next[g] ? 16'd0
                                               : clamp_us(channels[g], MIN32, MAX32);
    assign w_pwm_next[g]    = ({16'd0, r_shadow[g]} > w_count_next);
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_us_count    <= 32'd0;
      r_pwm         <= '0;
      r_frame_start <= 1'b0;
      r_clamp       <= '0;
      r_absent      <= '1;
      r_busy        <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_shadow[i] <= 16'd0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_pwm <= '0;
          if (enable) begin
            r_state       <= LATCH;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
          end else begin
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        LATCH: begin
          r_state       <= RUN;
          r_frame_start <= 1'b0;
          r_us_count    <= 32'd0;
          r_clamp       <= w_clamp_next;
          r_absent      <= w_absent_next;
          // Rising edge must appear on the first RUN cycle, before the shadow
          // registers are visible, so it is decoded from the incoming values.
          r_pwm         <= ~w_absent_next;
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_shadow[i] <= w_shadow_next[i];
          end
        end
        RUN: begin
          if (w_frame_end) begin
            r_us_count <= 32'd0;
            r_pwm      <= '0;
            if (enable) begin
              r_state       <= LATCH;
              r_frame_start <= 1'b1;
              r_busy        <= 1'b1;
            end else begin
              r_state       <= IDLE;
              r_frame_start <= 1'b0;
              r_busy        <= 1'b0;
            end
          end else begin
            r_us_count    <= w_count_next;
            r_pwm         <= w_pwm_next;
            r_frame_start <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_pwm         <= '0;
          r_frame_start <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign servo_pwm   = r_pwm;
  assign frame_start = r_frame_start;
  assign clamp_flags = r_clamp;
  assign absent_mask = r_absent;
  assign busy        = r_busy;

endmodule

// File: doc/ppm_servo_driver.md
Name: ppm_servo_driver

Overview:
- Downstream consumer of the PPM receiver's decoded channel array: eight 32-bit pulse widths, in microseconds.
- Regenerates eight standard hobby-servo PWM outputs at a fixed frame rate.
- Channel values are sampled into shadow registers once per frame, so receiver updates never cause runt or stretched pulses.
- Values are clamped to a safe servo range, and channels that never received data are reported.

Parameters:
- CLK_PER_US, 50, clock cycles per microsecond (50 MHz clk); minimum 2.
- FRAME_US, 20000, servo frame period in microseconds; must exceed MAX_US.
- MIN_US, 1000, minimum output pulse width in microseconds.
- MAX_US, 2000, maximum output pulse width in microseconds; must be < 65536.
- NUM_CHANNELS, 8, number of channels/outputs; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- channels  input  32 x [0:7] (unpacked array)  decoded pulse widths from the receiver, in microseconds
- enable  input  1  run servo frames while high
- servo_pwm  output  8  bit i is the PWM output for channel i
- frame_start  output  1  one-cycle pulse in LATCH
- clamp_flags  output  8  bit i set when channel i was clamped at the last latch
- absent_mask  output  8  bit i set when channel i was 0 at the last latch
- busy  output  1  high when state is not IDLE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; prescaler=0; us_count=0; shadow[*]=0.
  - servo_pwm=0, frame_start=0, clamp_flags=0, absent_mask=8'hFF, busy=0.
- States: IDLE, LATCH, RUN.
- IDLE:
  - servo_pwm=0.
  - enable=1 -> LATCH on the next clock; otherwise stay in IDLE.
- LATCH (exactly one cycle):
  - For each channel: if value==0, shadow=0 and absent bit=1. Otherwise shadow = clamp(value, MIN_US, MAX_US), and clamp bit=1 if value<MIN_US or value>MAX_US.
  - Comparisons are full 32-bit unsigned. shadow is 16 bits.
  - prescaler=0, us_count=0, frame_start=1.
  - Next state is RUN.
- RUN:
  - prescaler counts 0..CLK_PER_US-1; us_tick is asserted when prescaler==CLK_PER_US-1.
  - us_count increments on us_tick.
  - servo_pwm[i] is registered: servo_pwm[i] <= (us_count < shadow[i]). The rising edge appears on the first cycle after LATCH.
  - Pulse width = shadow[i]*CLK_PER_US cycles exactly. Absent channels stay low.
- End of frame (us_tick with us_count==FRAME_US-1):
  - enable=1 -> LATCH; enable=0 -> IDLE.
  - Frame period = FRAME_US*CLK_PER_US + 1 cycles (LATCH adds one cycle).
- enable deasserted mid-frame: the current frame completes untouched and no pulse is truncated, then the block enters IDLE.
- channels changing mid-frame: no effect until the next LATCH.
- clamp_flags and absent_mask update only in LATCH and hold otherwise, including while in IDLE.
- Reset mid-frame: all outputs drop immediately, asynchronously, to their reset values.
- Boundary values:
  - Value==MIN_US or MAX_US: no clamp flag.
  - Value==1: clamped to MIN_US, flag set.
  - Value==32'hFFFF_FFFF: clamped to MAX_US, flag set.

Decomposition:
- Shared package ppm_pkg holds:
  - the servo_state_t enum (IDLE, LATCH, RUN);
  - default constants for MIN_US, MAX_US and FRAME_US;
  - the NUM_CHANNELS constant, also used by the receiver.
- One natural sub-module, us_prescaler: takes clk, reset_n and a clear input, and produces us_tick. It is reusable by other timing blocks.
- The clamp/absent logic is a per-channel generate loop in the top level.

Test Plan:
- Basic frame. Stimulus: CLK_PER_US=2, FRAME_US=3000, enable=1, channels={1500,1000,2000,1200,1800,1100,1900,1600}. Required: each servo_pwm[i] high for exactly 2*value cycles; frame_start period 6001 cycles; clamp_flags=0; absent_mask=0.
- Clamping. Stimulus: channels[0]=500, channels[1]=2500, channels[2]=32'hFFFFFFFF, channels[3]=1000. Required: widths of 1000, 2000 and 2000 us; widths measured as 2000, 4000, 4000 and 2000 cycles; clamp_flags=8'b0000_0111.
- Absent channel. Stimulus: channels[5]=0, others 1500. Required: servo_pwm[5] never rises; absent_mask=8'b0010_0000.
- Mid-frame update. Stimulus: change channels[0] from 1500 to 1900 at us_count=100. Required: the current pulse is still 1500 us; the next frame's pulse is 1900 us.
- Enable drop. Stimulus: deassert enable at us_count=1200. Required: the frame completes with the 1500 us pulses intact; busy=0 after the last us_tick; no further frame_start.
- Async reset. Stimulus: assert reset_n=0 while servo_pwm=8'hFF. Required: servo_pwm=0 with no clock edge; absent_mask=8'hFF; after release the state is IDLE.
